// File: rtl/sort_pkg.sv
// Shared types and constants for the sort engine memory responder.
// Holds default widths, response codes and the read/write handshake state enums.
package sort_pkg;

    localparam int ADDR_WDTH_DEF = 4;
    localparam int DATA_WDTH_DEF = 32;
    localparam int RESP_WDTH_DEF = 1;

    localparam int RESP_OKAY   = 0;
    localparam int RESP_SLVERR = 1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

endpackage

// File: rtl/sort_mem_regfile.sv
// Register file holding the array under sort: one synchronous write port,
// one combinational read port, cleared to zero by synchronous reset.
module sort_mem_regfile #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [ADDR_WDTH-1:0] waddr_i,
    input  logic [DATA_WDTH-1:0] wdata_i,
    input  logic [ADDR_WDTH-1:0] raddr_i,
    output logic [DATA_WDTH-1:0] rdata_o
);

    logic [DATA_WDTH-1:0] mem_q [2**ADDR_WDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_WDTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reading the pre-edge contents gives read-first behaviour on a same-edge collision.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sort_mem_responder.sv
// Memory responder for the sort engine: AR/R and AW/W/B handshake FSMs over a register file.
// Optional macro SORT_MEM_RANGE_CHECK_EN flags accesses at or beyond arr_size with SLVERR.
module sort_mem_responder
    import sort_pkg::*;
#(
    parameter int ADDR_WDTH = ADDR_WDTH_DEF,
    parameter int DATA_WDTH = DATA_WDTH_DEF,
    parameter int RESP_WDTH = RESP_WDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_WDTH-1:0] arr_size,
    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [ADDR_WDTH-1:0] ar_address,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_WDTH-1:0] aw_address,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [RESP_WDTH-1:0] b_resp
);

    rd_state_e            rdState_q, rdState_d;
    logic [DATA_WDTH-1:0] rData_q, rData_d;
    logic [RESP_WDTH-1:0] rResp_q, rResp_d;

    wr_state_e            wrState_q, wrState_d;
    logic                 awGot_q, awGot_d;
    logic                 wGot_q, wGot_d;
    logic [ADDR_WDTH-1:0] awAddr_q, awAddr_d;
    logic                 awErr_q, awErr_d;
    logic [DATA_WDTH-1:0] wData_q, wData_d;
    logic [RESP_WDTH-1:0] bResp_q, bResp_d;

    logic                 arHs, rHs, awHs, wHs, bHs;
    logic                 rdErrNow, awErrNow;
    logic                 commit, memWe, wrErr;
    logic [ADDR_WDTH-1:0] wrAddr;
    logic [DATA_WDTH-1:0] wrData;
    logic [DATA_WDTH-1:0] memRdata;

`ifdef SORT_MEM_RANGE_CHECK_EN
    assign rdErrNow = (ar_address >= arr_size);
    assign awErrNow = (aw_address >= arr_size);
`else
    logic unusedArrSize;
    assign unusedArrSize = ^arr_size;
    assign rdErrNow      = 1'b0;
    assign awErrNow      = 1'b0;
`endif

    assign arHs = ar_valid && ar_ready;
    assign rHs  = r_valid && r_ready;
    assign awHs = aw_valid && aw_ready;
    assign wHs  = w_valid && w_ready;
    assign bHs  = b_valid && b_ready;

    // Whichever half arrives last is taken straight from the bus so the commit needs no extra cycle.
    assign wrAddr = awGot_q ? awAddr_q : aw_address;
    assign wrData = wGot_q ? wData_q : w_data;
    assign wrErr  = awGot_q ? awErr_q : awErrNow;
    assign commit = (wrState_q == W_IDLE) && (awGot_q || awHs) && (wGot_q || wHs);
    assign memWe  = commit && !wrErr;

    sort_mem_regfile #(
        .ADDR_WDTH(ADDR_WDTH),
        .DATA_WDTH(DATA_WDTH)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (memWe),
        .waddr_i(wrAddr),
        .wdata_i(wrData),
        .raddr_i(ar_address),
        .rdata_o(memRdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdState_q <= R_IDLE;
            rData_q   <= '0;
            rResp_q   <= '0;
            wrState_q <= W_IDLE;
            awGot_q   <= 1'b0;
            wGot_q    <= 1'b0;
            awAddr_q  <= '0;
            awErr_q   <= 1'b0;
            wData_q   <= '0;
            bResp_q   <= '0;
        end else begin
            rdState_q <= rdState_d;
            rData_q   <= rData_d;
            rResp_q   <= rResp_d;
            wrState_q <= wrState_d;
            awGot_q   <= awGot_d;
            wGot_q    <= wGot_d;
            awAddr_q  <= awAddr_d;
            awErr_q   <= awErr_d;
            wData_q   <= wData_d;
            bResp_q   <= bResp_d;
        end
    end

    always_comb begin
        rdState_d = rdState_q;
        rData_d   = rData_q;
        rResp_d   = rResp_q;
        case (rdState_q)
            R_IDLE: begin
                if (arHs) begin
                    rdState_d = R_RESP;
                    rData_d   = rdErrNow ? '0 : memRdata;
                    rResp_d   = rdErrNow ? RESP_WDTH'(RESP_SLVERR) : RESP_WDTH'(RESP_OKAY);
                end
            end
            R_RESP: begin
                if (rHs) begin
                    rdState_d = R_IDLE;
                end
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    always_comb begin
        wrState_d = wrState_q;
        awGot_d   = awGot_q;
        wGot_d    = wGot_q;
        awAddr_d  = awAddr_q;
        awErr_d   = awErr_q;
        wData_d   = wData_q;
        bResp_d   = bResp_q;
        case (wrState_q)
            W_IDLE: begin
                if (commit) begin
                    wrState_d = W_RESP;
                    awGot_d   = 1'b0;
                    wGot_d    = 1'b0;
                    bResp_d   = wrErr ? RESP_WDTH'(RESP_SLVERR) : RESP_WDTH'(RESP_OKAY);
                end else begin
                    if (awHs) begin
                        awGot_d  = 1'b1;
                        awAddr_d = aw_address;
                        awErr_d  = awErrNow;
                    end
                    if (wHs) begin
                        wGot_d  = 1'b1;
                        wData_d = w_data;
                    end
                end
            end
            W_RESP: begin
                if (bHs) begin
                    wrState_d = W_IDLE;
                end
            end
            default: wrState_d = W_IDLE;
        endcase
    end

    // Readies are held low while rst_n is asserted even though the state already reads idle.
    always_comb begin
        ar_ready = rst_n && (rdState_q == R_IDLE);
        r_valid  = (rdState_q == R_RESP);
        aw_ready = rst_n && (wrState_q == W_IDLE) && !awGot_q;
        w_ready  = rst_n && (wrState_q == W_IDLE) && !wGot_q;
        b_valid  = (wrState_q == W_RESP);
    end

    assign r_data = rData_q;
    assign r_resp = rResp_q;
    assign b_resp = bResp_q;

endmodule
